fft_stage_sequencer: RTL and testbench

Control FSM for the in-place radix-2 DIT FFT. It walks all log2(N) stages and, for each stage, every butterfly. For each butterfly it issues the two data-RAM operand addresses and the twiddle-ROM address to the butterfly datapath over a valid/ready handshake. Between stages it inserts a programmable pipeline-drain gap so the next stage never reads a result that has not yet been written back. It sits between the FFT top-level start/done control and the data RAM, twiddle ROM and butterfly pipeline.

---
 rtl/fft_stage_sequencer.sv | 134 +++++++++++++
 tb/tb_fft_stage_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly address sequencer for an in-place radix-2 DIT FFT.
// Walks every stage and butterfly, issuing operand and twiddle addresses, with a drain gap between stages.
module fft_stage_sequencer #(
  parameter int N_LOG2   = 12,
  parameter int TW_AW    = 12,
  parameter int PIPE_LAT = 4,
  localparam int SW      = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     stage,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic              bf_last,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [TW_AW-1:0]  tw_addr
);

  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [N_LOG2-1:0] C_LAST     = N_LOG2'((2 ** (N_LOG2 - 1)) - 1);
  localparam logic [SW-1:0]     S_LAST     = SW'(N_LOG2 - 1);
  localparam logic [DW-1:0]     DRAIN_LOAD = DW'(PIPE_LAT);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t            state, nxt_state;
  logic [N_LOG2-1:0] c, nxt_c;
  logic [SW-1:0]     s, nxt_s;
  logic [DW-1:0]     drain, nxt_drain;
  logic              nxt_run;

  function automatic logic [N_LOG2-1:0] low_mask(input logic [SW-1:0] ss);
    return ~({N_LOG2{1'b1}} << ss);
  endfunction

  // Upper leg: a zero spliced into the butterfly index at bit position s.
  function automatic logic [N_LOG2-1:0] calc_a(input logic [N_LOG2-1:0] cc,
                                               input logic [SW-1:0] ss);
    logic [N_LOG2-1:0] m;
    m = low_mask(ss);
    return ((cc & ~m) << 1) | (cc & m);
  endfunction

  function automatic logic [N_LOG2-1:0] calc_b(input logic [N_LOG2-1:0] cc,
                                               input logic [SW-1:0] ss);
    logic [N_LOG2-1:0] one;
    one = N_LOG2'(1);
    return calc_a(cc, ss) | (one << ss);
  endfunction

  function automatic logic [TW_AW-1:0] calc_tw(input logic [N_LOG2-1:0] cc,
                                               input logic [SW-1:0] ss);
    logic [TW_AW-1:0] j;
    j = TW_AW'(cc & low_mask(ss));
    return j << (TW_AW - 1 - int'(ss));
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_c     = c;
    nxt_s     = s;
    nxt_drain = drain;
    case (state)
      ST_IDLE: begin
        if (start) begin
          nxt_c     = '0;
          nxt_s     = '0;
          nxt_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bf_ready) begin
          if (c == C_LAST) begin
            nxt_c     = '0;
            nxt_drain = DRAIN_LOAD;
            nxt_state = ST_DRAIN;
          end else begin
            nxt_c = c + N_LOG2'(1);
          end
        end
      end
      ST_DRAIN: begin
        nxt_drain = drain - DW'(1);
        if (drain == DW'(1)) begin
          if (s == S_LAST) begin
            nxt_state = ST_DONE;
          end else begin
            nxt_s     = s + SW'(1);
            nxt_state = ST_RUN;
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  assign nxt_run = (nxt_state == ST_RUN);

  // Outputs are registered from next-state values, so bf_ready never reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      c        <= '0;
      s        <= '0;
      drain    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bf_valid <= 1'b0;
      bf_last  <= 1'b0;
      stage    <= '0;
      addr_a   <= '0;
      addr_b   <= '0;
      tw_addr  <= '0;
    end else begin
      state    <= nxt_state;
      c        <= nxt_c;
      s        <= nxt_s;
      drain    <= nxt_drain;
      busy     <= (nxt_state != ST_IDLE);
      done     <= (nxt_state == ST_DONE);
      bf_valid <= nxt_run;
      bf_last  <= nxt_run && (nxt_c == C_LAST);
      stage    <= nxt_s;
      addr_a   <= nxt_run ? calc_a(nxt_c, nxt_s) : '0;
      addr_b   <= nxt_run ? calc_b(nxt_c, nxt_s) : '0;
      tw_addr  <= nxt_run ? calc_tw(nxt_c, nxt_s) : '0;
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: a small instance (N=8) checked cycle-by-cycle against a
// command-queue model, plus a default-size instance checked over a full transform.
module tb_fft_stage_sequencer;

  localparam int SN = 3, STW = 12, SPL = 2;
  localparam int SSW = (SN > 1) ? $clog2(SN) : 1;
  localparam int S_HALF = 1 << (SN - 1);
  localparam int S_DONE_REL = 1 + SN * (S_HALF + SPL);
  localparam int DN = 12, DTW = 12, DPL = 4;
  localparam int DSW = (DN > 1) ? $clog2(DN) : 1;
  localparam int D_HALF = 1 << (DN - 1);

  // clock / reset
  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           start, busy, done, bf_valid, bf_ready, bf_last;
  logic [SSW-1:0] stage;
  logic [SN-1:0]  addr_a, addr_b;
  logic [STW-1:0] tw_addr;

  logic           d_start, d_busy, d_done, d_valid, d_ready, d_last;
  logic [DSW-1:0] d_stage;
  logic [DN-1:0]  d_addr_a, d_addr_b;
  logic [DTW-1:0] d_tw;

  fft_stage_sequencer #(.N_LOG2(SN), .TW_AW(STW), .PIPE_LAT(SPL)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .stage(stage),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_last(bf_last),
    .addr_a(addr_a), .addr_b(addr_b), .tw_addr(tw_addr));

  fft_stage_sequencer #(.N_LOG2(DN), .TW_AW(DTW), .PIPE_LAT(DPL)) u_def (
    .clk(clk), .rst_n(rst_n), .start(d_start), .busy(d_busy), .done(d_done), .stage(d_stage),
    .bf_valid(d_valid), .bf_ready(d_ready), .bf_last(d_last),
    .addr_a(d_addr_a), .addr_b(d_addr_b), .tw_addr(d_tw));

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference address arithmetic, plain integer form
  function automatic int ref_a(input int s, input int c);
    int h;
    h = 1 << s;
    return (c / h) * (2 * h) + (c % h);
  endfunction

  function automatic int ref_b(input int s, input int c);
    return ref_a(s, c) + (1 << s);
  endfunction

  function automatic int ref_tw(input int tw_aw, input int s, input int c);
    return (c % (1 << s)) * (1 << (tw_aw - 1 - s));
  endfunction

  typedef struct {
    int a;
    int b;
    int tw;
    int st;
    bit last;
  } cmd_t;

  // scoreboard: expected command stream of the small instance
  cmd_t exp_q[$];
  int   cyc = 0;
  bit   m_busy, m_done;
  int   m_gap, m_e0, stalls, done_cnt, last_done_rel;
  bit   rec_en;
  bit   vh[32], bh[32];
  int   acc_n;
  int   acc_a[12], acc_b[12], acc_tw[12];
  bit   acc_last[12];
  int   mon_rel;
  bit   mon_ev;
  cmd_t hd;
  bit   rand_ready;

  int lit_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int lit_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int lit_tw[12] = '{0, 0, 0, 0, 0, 1024, 0, 1024, 0, 512, 1024, 1536};

  initial begin
    m_busy = 0; m_done = 0; m_gap = 0; m_e0 = 1 << 30; stalls = 0;
    done_cnt = 0; last_done_rel = 0; rec_en = 0; acc_n = 0; rand_ready = 0;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) bf_ready = 1'($urandom_range(0, 1));
  end

  // compare process for the small instance
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_gap = 0;
      exp_q.delete();
    end else begin
      mon_ev = m_busy && !m_done && (m_gap == 0) && (exp_q.size() > 0);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("bf_valid", bf_valid, mon_ev);
      if (mon_ev && bf_valid) begin
        hd = exp_q[0];
        check("addr_a", addr_a, hd.a);
        check("addr_b", addr_b, hd.b);
        check("tw_addr", tw_addr, hd.tw);
        check("stage", stage, hd.st);
        check("bf_last", bf_last, hd.last);
        if (rec_en && bf_ready && acc_n < 12) begin
          acc_a[acc_n] = int'(addr_a); acc_b[acc_n] = int'(addr_b);
          acc_tw[acc_n] = int'(tw_addr); acc_last[acc_n] = bf_last;
          acc_n++;
        end
      end
      mon_rel = cyc - m_e0 + 1;
      if (rec_en && mon_rel >= 1 && mon_rel < 32) begin
        vh[mon_rel] = bf_valid;
        bh[mon_rel] = busy;
      end
      if (done) begin
        done_cnt++;
        last_done_rel = mon_rel;
        check("done_cycle", mon_rel, S_DONE_REL + stalls);
      end
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_gap = 0; stalls = 0; m_e0 = cyc + 1;
          exp_q.delete();
          for (int s = 0; s < SN; s++)
            for (int c = 0; c < S_HALF; c++)
              exp_q.push_back('{ref_a(s, c), ref_b(s, c), ref_tw(STW, s, c), s, c == S_HALF - 1});
        end
      end else if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0 && exp_q.size() == 0) m_done = 1;
      end else if (exp_q.size() > 0) begin
        if (bf_ready) begin
          hd = exp_q.pop_front();
          if (hd.last) m_gap = SPL;
        end else begin
          stalls++;
        end
      end
    end
  end

  // compare process for the default instance
  int d_xfers = 0, d_e0 = 1 << 30, d_done_cnt = 0, d_done_rel = 0;
  int d_last_a = 0, d_last_b = 0, d_last_tw = 0;
  int d_s, d_c;
  logic [63:0] d_exp;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!d_busy && d_start) d_e0 = cyc + 1;
      if (d_valid) begin
        d_s = d_xfers / D_HALF;
        d_c = d_xfers % D_HALF;
        d_exp = {23'd0, DN'(ref_a(d_s, d_c)), DN'(ref_b(d_s, d_c)), DTW'(ref_tw(DTW, d_s, d_c)),
                 DSW'(d_s), 1'(d_c == D_HALF - 1)};
        if (d_xfers >= DN * D_HALF) check("def_extra_valid", d_xfers, DN * D_HALF - 1);
        else check("def_cmd", {23'd0, d_addr_a, d_addr_b, d_tw, d_stage, d_last}, d_exp);
        if (d_ready) begin
          d_last_a = int'(d_addr_a); d_last_b = int'(d_addr_b); d_last_tw = int'(d_tw);
          d_xfers++;
        end
      end
      if (d_done) begin
        d_done_cnt++;
        d_done_rel = cyc - d_e0 + 1;
      end
    end
  end

  // driver tasks
  task automatic run_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_start_after(input int n);
    repeat (n) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0, k;
    n0 = done_cnt;
    k = 0;
    while (done_cnt == n0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("done_arrived", done_cnt - n0, 1);
  endtask

  task automatic check_small_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, bf_valid, 0);
    check({tag, "_last"}, bf_last, 0);
    check({tag, "_stage"}, stage, 0);
    check({tag, "_a"}, addr_a, 0);
    check({tag, "_b"}, addr_b, 0);
    check({tag, "_tw"}, tw_addr, 0);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; start = 1'b0; bf_ready = 1'b0; d_start = 1'b0; d_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_small_zero("rst");
    check("rst_def_valid", d_valid, 0);
    check("rst_def_b", d_addr_b, 0);
    rst_n = 1'b1;

    // ready held high: cycle-exact timeline and literal address table
    bf_ready = 1'b1;
    rec_en = 1'b1;
    run_start();
    wait_done(200);
    repeat (2) @(posedge clk);
    #1 rec_en = 1'b0;
    check("ready_high_done_rel", last_done_rel, 19);
    for (int r = 1; r <= 20; r++) begin
      check($sformatf("valid_c%0d", r), vh[r],
            (r >= 1 && r <= 4) || (r >= 7 && r <= 10) || (r >= 13 && r <= 16));
      check($sformatf("busy_c%0d", r), bh[r], r <= 19);
    end
    check("accepted_count", acc_n, 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("lit_a%0d", i), acc_a[i], lit_a[i]);
      check($sformatf("lit_b%0d", i), acc_b[i], lit_b[i]);
      check($sformatf("lit_tw%0d", i), acc_tw[i], lit_tw[i]);
      check($sformatf("lit_last%0d", i), acc_last[i], (i % 4) == 3);
    end

    // start pulses in cycles 3, 6 and 19 (the done cycle) are ignored
    n0 = done_cnt;
    run_start();
    pulse_start_after(2);
    pulse_start_after(2);
    pulse_start_after(12);
    check("busy_start_done_count", done_cnt - n0, 1);
    check("busy_start_done_rel", last_done_rel, 19);
    repeat (3) @(posedge clk);
    #1 check("idle_after_done", busy, 0);
    run_start();
    check("restart_stage", stage, 0);
    check("restart_a", addr_a, 0);
    check("restart_b", addr_b, 1);
    wait_done(200);

    // random backpressure
    rand_ready = 1'b1;
    repeat (4) begin
      run_start();
      wait_done(600);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1 bf_ready = 1'b1;

    // reset in the middle of stage 1, c=2
    run_start();
    repeat (8) @(posedge clk);
    #1;
    check("mid_stage", stage, 1);
    check("mid_a", addr_a, 4);
    check("mid_b", addr_b, 6);
    rst_n = 1'b0;
    #1 check_small_zero("midrst");
    @(posedge clk);
    #1 check_small_zero("midrst_hold");
    rst_n = 1'b1;
    run_start();
    check("post_rst_valid", bf_valid, 1);
    check("post_rst_stage", stage, 0);
    check("post_rst_a", addr_a, 0);
    check("post_rst_b", addr_b, 1);
    check("post_rst_tw", tw_addr, 0);
    wait_done(200);

    // default-size transform with ready high
    @(posedge clk);
    #1 d_ready = 1'b1; d_start = 1'b1;
    @(posedge clk);
    #1 d_start = 1'b0;
    for (int k = 0; k < 30000 && d_done_cnt == 0; k++) @(posedge clk);
    #1;
    check("def_done_count", d_done_cnt, 1);
    check("def_done_rel", d_done_rel, 24625);
    check("def_xfers", d_xfers, DN * D_HALF);
    check("def_final_a", d_last_a, 2047);
    check("def_final_b", d_last_b, 4095);
    check("def_final_tw", d_last_tw, 2047);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
